// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: 2-flop sync, 16x oversampling, 3-sample majority vote, valid/ready byte output with error pulses.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT output FIFO; default is a single holding register.

`ifdef UART_RX_FIFO_EN
module uart_rx_deframer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + PTR_ONE;
    end
    if (do_pop) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end
endmodule
`endif

module uart_rx_deframer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_deframer: CLK_HZ too low for BAUD (DIV < 1)");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_deframer: FIFO_DEPTH must be a power of 2 >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    s_q, s_d, s_nxt;
  logic [1:0]    vote_q, vote_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rx_s, tick, vote, eval, push;

  assign sync_d = {sync_q[0], uart_rx};
  assign rx_s   = sync_q[1];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    s_d     = s_q;
    vote_d  = vote_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    tick    = (state_q != S_IDLE) && (presc_q == PW'(DIV - 1));
    s_nxt   = s_q + 4'd1;
    // vote_q holds the samples taken as s became 7 and 8; rx_s is the s=9 sample.
    vote    = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
    eval    = tick && (s_nxt == 4'd9);

    if (state_q != S_IDLE) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        s_d    = s_nxt;
        vote_d = {vote_q[0], rx_s};
      end
    end

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        s_d     = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (eval) begin
          bit_d   = '0;
          state_d = vote ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (eval) begin
          shift_d = {vote, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop re-arms early enough for back-to-back frames with baud skew.
        if (eval) begin
          if (vote) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            presc_d = '0;
            s_d     = '0;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Need 16 consecutive high ticks; any low sample restarts the count.
        if (!rx_s) begin
          presc_d = '0;
          s_d     = '0;
        end else if (tick && s_q == 4'd15) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_empty, fifo_full;

  uart_rx_deframer_fifo #(
    .W    (8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (shift_q),
    .pop  (rx_ready),
    .dout (rx_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign rx_valid = !fifo_empty;
  assign ovr_d    = push && fifo_full && !rx_ready;
`else
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (push) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      presc_q <= '0;
      s_q     <= '0;
      vote_q  <= 2'b11;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      presc_q <= presc_d;
      s_q     <= s_d;
      vote_q  <= vote_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer at DIV=10 (160 clk per bit): table of single frames plus timed corner-case sequences.
module tb_uart_rx_deframer;
  localparam int  CLK_HZ = 18_432_000;
  localparam int  BAUD   = 115200;
  localparam real BIT_T  = 1600.0;
`ifdef UART_RX_FIFO_EN
  localparam int EXP_KEEP = 8;
  localparam int EXP_OVR  = 2;
`else
  localparam int EXP_KEEP = 1;
  localparam int EXP_OVR  = 9;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_deframer #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: transfers, error pulses, busy cycles, and hold stability under backpressure.
  logic [7:0] rxq[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         busy_cnt = 0;
  int         first_vld_cyc = -1;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_dat = 8'h00;

  always @(negedge clk) begin
    if (reset && hold_prev) check("hold_stable", {rx_valid, rx_data}, {1'b1, hold_dat});
    hold_prev = reset && rx_valid && !rx_ready;
    hold_dat  = rx_data;
    if (rx_valid && rx_ready) begin
      rxq.push_back(rx_data);
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_mon();
    rxq.delete();
    ferr_cnt      = 0;
    ovr_cnt       = 0;
    busy_cnt      = 0;
    first_vld_cyc = -1;
  endtask

  function automatic logic [31:0] q_at(input int idx);
    if (idx < rxq.size()) return {24'd0, rxq[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  // Leaves the line at the stop-bit level; noise adds a one-clock low blip mid-bit on 1 bits.
  task automatic send_byte(input logic [7:0] b, input logic stop, input real bit_t, input bit noise);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      if (noise && fr[i]) begin
        #800;
        uart_rx = 1'b0;
        #10;
        uart_rx = fr[i];
        #(bit_t - 810.0);
      end else begin
        #(bit_t);
      end
    end
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         exp_n;
    int         exp_ferr;
  } vec_t;

  vec_t       vt[5];
  logic [7:0] exp7[16];
  int         t0;

  initial begin
    vt[0] = '{8'hA5, 1'b1, 1, 0};
    vt[1] = '{8'h00, 1'b1, 1, 0};
    vt[2] = '{8'hFF, 1'b1, 1, 0};
    vt[3] = '{8'h81, 1'b1, 1, 0};
    vt[4] = '{8'h3C, 1'b0, 0, 1};
    for (int i = 0; i < 8; i++) exp7[i] = 8'(i * 37 + 11);
    for (int i = 0; i < 8; i++) exp7[8 + i] = 8'(i * 53 + 7);

    reset    = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rx_valid, rx_data, frame_err, overrun, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {rx_valid, frame_err, overrun, busy}, 32'd0);
    @(posedge clk); #1;
    rx_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      clear_mon();
      send_byte(vt[i].dat, vt[i].stop, BIT_T, 1'b0);
      uart_rx = 1'b1;
      repeat (300) @(posedge clk);
      check("vec_nval", rxq.size(), vt[i].exp_n);
      check("vec_ferr", ferr_cnt, vt[i].exp_ferr);
      check("vec_ovr", ovr_cnt, 0);
      if (vt[i].exp_n != 0) check("vec_data", q_at(0), {24'd0, vt[i].dat});
    end

    // Byte latency from the start edge: 3 clk sync/detect + 153 ticks of 10 clk.
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc;
    send_byte(8'hA5, 1'b1, BIT_T, 1'b0);
    repeat (200) @(posedge clk);
    check("t1_nval", rxq.size(), 1);
    check("t1_data", q_at(0), 32'hA5);
    check_rng("t1_latency", first_vld_cyc - t0, 1530, 1536);
    check("t1_err", ferr_cnt + ovr_cnt, 0);

    // 40-clk glitch: false start, busy ~90 clk.
    clear_mon();
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (200) @(posedge clk);
    check_rng("t2_busy_cycles", busy_cnt, 86, 94);
    check("t2_nval", rxq.size(), 0);
    check("t2_ferr", ferr_cnt, 0);

    // Bad stop bit then long low line: one frame_err, BREAK until 16 ticks of high.
    clear_mon();
    send_byte(8'h3C, 1'b0, BIT_T, 1'b0);
    uart_rx = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check("t3_busy_in_break", busy, 1);
    uart_rx = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_rng("t3_break_release", cyc - t0, 158, 166);
    check("t3_ferr", ferr_cnt, 1);
    check("t3_nval", rxq.size(), 0);
    check("t3_ovr", ovr_cnt, 0);

    // Backpressure overrun.
    clear_mon();
    @(posedge clk); #1;
    rx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b1, BIT_T, 1'b0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("t4_ovr", ovr_cnt, EXP_OVR);
    check("t4_valid", rx_valid, 1);
    check("t4_data", rx_data, 32'h01);
    check("t4_ferr", ferr_cnt, 0);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    repeat (20) @(posedge clk);
    check("t4_drain_n", rxq.size(), EXP_KEEP);
    for (int i = 0; i < EXP_KEEP; i++) check("t4_drain_data", q_at(i), i + 1);

    // Single-clock noise inside every 1 bit.
    clear_mon();
    send_byte(8'h5A, 1'b1, BIT_T, 1'b1);
    repeat (300) @(posedge clk);
    check("t5_nval", rxq.size(), 1);
    check("t5_data", q_at(0), 32'h5A);
    check("t5_err", ferr_cnt + ovr_cnt, 0);

    // Reset mid-frame, then a clean byte.
    clear_mon();
    @(posedge clk); #1;
    fork
      send_byte(8'hFF, 1'b1, BIT_T, 1'b0);
      begin
        #(BIT_T * 3.0);
        check("t6_busy_pre", busy, 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_in_reset", {rx_valid, rx_data, frame_err, overrun, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
      end
    join
    repeat (300) @(posedge clk);
    send_byte(8'h42, 1'b1, BIT_T, 1'b0);
    repeat (300) @(posedge clk);
    check("t6_nval", rxq.size(), 1);
    check("t6_data", q_at(0), 32'h42);
    check("t6_err", ferr_cnt + ovr_cnt, 0);

    // Baud skew +3% then -3%, back-to-back.
    clear_mon();
    for (int i = 0; i < 8; i++) send_byte(exp7[i], 1'b1, BIT_T / 1.03, 1'b0);
    repeat (300) @(posedge clk);
    for (int i = 0; i < 8; i++) send_byte(exp7[8 + i], 1'b1, BIT_T / 0.97, 1'b0);
    repeat (300) @(posedge clk);
    check("t7_nval", rxq.size(), 16);
    for (int i = 0; i < 16; i++) check("t7_data", q_at(i), {24'd0, exp7[i]});
    check("t7_ferr", ferr_cnt, 0);
    check("t7_ovr", ovr_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
